// File: rtl/sap1_pkg.sv
// Shared constants and types for the SAP-1 memory block.
// No logic and no latency of its own.
// No backpressure; it only carries definitions.
package sap1_pkg;

    localparam int SAP1_ADDR_W = 4;
    localparam int SAP1_DATA_W = 8;
    localparam int SAP1_DEPTH  = 1 << SAP1_ADDR_W;

    // Loader session state: waiting for program mode, accepting bytes, or full
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ram_ldr_state_t;

    // Sequential load address step; wraps naturally at the address width
    function automatic logic [SAP1_ADDR_W-1:0] ldr_next_addr(input logic [SAP1_ADDR_W-1:0] a);
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/sap1_ram_loader.sv
// Byte-stream loader FSM: fills memory sequentially from address 0 in program mode.
// Write strobe is combinational with the handshake; status flags update one cycle later.
// prog_ready is high only in LOAD; prog_valid outside LOAD is ignored (flagged as an error in DONE).
module ram_loader
    import sap1_pkg::*;
#(
    parameter int ADDR_W = SAP1_ADDR_W,
    parameter int DEPTH  = SAP1_DEPTH
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              prog_mode,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              prog_err,
    output logic [ADDR_W-1:0] prog_count,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_ldr_state_t    state, state_nxt;
    logic [ADDR_W-1:0] count_nxt;
    logic              done_nxt;
    logic              err_nxt;

    // State and status registers; memory contents are deliberately outside this reset
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state      <= IDLE;
            prog_count <= '0;
            prog_done  <= 1'b0;
            prog_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            prog_count <= count_nxt;
            prog_done  <= done_nxt;
            prog_err   <= err_nxt;
        end
    end

    // Next-state, handshake and write-strobe decode
    always_comb begin
        state_nxt  = state;
        count_nxt  = prog_count;
        done_nxt   = prog_done;
        err_nxt    = prog_err;
        prog_ready = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                // Entering a new session clears the previous session's flags
                if (prog_mode) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            LOAD: begin
                prog_ready = 1'b1;
                if (prog_valid) begin
                    wr_en     = 1'b1;
                    count_nxt = ldr_next_addr(prog_count);
                    if (prog_count == LAST_ADDR) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
                // Leaving program mode aborts; a handshake in this cycle still writes
                if (!prog_mode) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                // Memory is full: any further byte is an overrun, never written
                if (prog_valid) begin
                    err_nxt = 1'b1;
                end
                if (!prog_mode) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign wr_addr = prog_count;

endmodule

// File: rtl/sap1_ram.sv
// 16x8 SAP-1 program/data memory with asynchronous read toward the W bus and a streaming loader.
// Read path is zero latency (combinational from addr); loader writes land on the accepting edge.
// Loader exerts backpressure via prog_ready; the read path has none and never drives in program mode.
module sap1_ram
    import sap1_pkg::*;
#(
    parameter int ADDR_W = SAP1_ADDR_W,
    parameter int DATA_W = SAP1_DATA_W,
    parameter int DEPTH  = SAP1_DEPTH
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] addr,
    input  logic              CE_bar,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              prog_err,
    output logic [ADDR_W-1:0] prog_count,
    output logic              ram_out_en,
    output logic [DATA_W-1:0] ram_output
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    ram_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_loader (
        .CLK        (CLK),
        .CLR        (CLR),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_err   (prog_err),
        .prog_count (prog_count),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr)
    );

    // Write port; unreset so a loaded program survives a CPU clear
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= prog_data;
        end
    end

    // Bus is driven only in run mode with the controller's enable; otherwise it reads as zero
    assign ram_out_en = ~CE_bar & ~prog_mode;
    assign ram_output = ram_out_en ? mem[addr] : '0;

endmodule

// File: tb/tb_sap1_ram.sv
module tb_sap1_ram;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [3:0] addr;
    logic       CE_bar;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic       prog_done;
    logic       prog_err;
    logic [3:0] prog_count;
    logic       ram_out_en;
    logic [7:0] ram_output;

    always #5 CLK = ~CLK;

    sap1_ram dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .addr       (addr),
        .CE_bar     (CE_bar),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_err   (prog_err),
        .prog_count (prog_count),
        .ram_out_en (ram_out_en),
        .ram_output (ram_output)
    );

    // Expected observations, queued by stimulus and consumed by the monitor
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;
    chk_t exp_q[$];

    localparam int K_READY = 0, K_DONE = 1, K_ERR = 2, K_COUNT = 3, K_EN = 4, K_OUT = 5, K_ACC = 6;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;

    // Reference model: loading session described as "in session / memory full" plus a byte array
    logic [7:0] m_mem [16];
    bit         m_in_session;
    bit         m_full;
    int         m_loaded;
    bit         m_done;
    bit         m_err;

    // Independent count of accepted bytes as seen on the interface
    always @(posedge CLK) begin
        if (!CLR && prog_valid && prog_ready) acc_cnt++;
    end

    function automatic logic [31:0] act(input int k);
        case (k)
            K_READY: return 32'(prog_ready);
            K_DONE:  return 32'(prog_done);
            K_ERR:   return 32'(prog_err);
            K_COUNT: return 32'(prog_count);
            K_EN:    return 32'(ram_out_en);
            K_OUT:   return 32'(ram_output);
            default: return 32'(acc_cnt);
        endcase
    endfunction

    // Monitor: compares every queued expectation on the falling edge
    always @(negedge CLK) begin
        chk_t        c;
        logic [31:0] a;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            a = act(c.kind);
            n_tests++;
            if (a !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, a, c.exp);
            end
        end
    end

    task automatic expect_v(input int k, input logic [31:0] e, input string n);
        chk_t c;
        c.kind = k;
        c.exp  = e;
        c.name = n;
        exp_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_status(input string tag);
        expect_v(K_READY, 32'(m_in_session && !m_full), {tag, " prog_ready"});
        expect_v(K_DONE,  32'(m_done),                  {tag, " prog_done"});
        expect_v(K_ERR,   32'(m_err),                   {tag, " prog_err"});
        expect_v(K_COUNT, 32'(m_loaded % 16),           {tag, " prog_count"});
    endtask

    task automatic enter_load();
        prog_mode = 1'b1;
        tick();
        m_in_session = 1'b1;
        m_full       = 1'b0;
        m_loaded     = 0;
        m_done       = 1'b0;
        m_err        = 1'b0;
    endtask

    task automatic leave_load();
        prog_mode = 1'b0;
        tick();
        m_in_session = 1'b0;
        m_full       = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; prog_valid is left high for back-to-back use
    task automatic send(input logic [7:0] b, input int gap);
        if (gap > 0) begin
            prog_valid = 1'b0;
            repeat (gap) tick();
        end
        prog_valid = 1'b1;
        prog_data  = b;
        tick();
        if (m_in_session && !m_full) begin
            m_mem[m_loaded % 16] = b;
            m_loaded++;
            if (m_loaded == 16) begin
                m_full = 1'b1;
                m_done = 1'b1;
            end
        end else if (m_in_session && m_full) begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_read(input int a, input string tag);
        addr   = 4'(a);
        CE_bar = 1'b0;
        expect_v(K_EN,  32'd1,          {tag, " ram_out_en"});
        expect_v(K_OUT, 32'(m_mem[a]),  $sformatf("%s ram_output[%0d]", tag, a));
        tick();
    endtask

    initial begin
        int acc0;
        CLR        = 1'b1;
        addr       = 4'd0;
        CE_bar     = 1'b1;
        prog_mode  = 1'b0;
        prog_valid = 1'b0;
        prog_data  = 8'd0;
        m_in_session = 1'b0;
        m_full       = 1'b0;
        m_loaded     = 0;
        m_done       = 1'b0;
        m_err        = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

        // Reset state
        repeat (2) tick();
        CLR = 1'b0;
        expect_status("reset");
        expect_v(K_EN,  32'd0, "reset ram_out_en");
        expect_v(K_OUT, 32'd0, "reset ram_output");
        tick();

        // Full back-to-back load of 0x10..0x1F
        enter_load();
        expect_status("load entry");
        acc0 = acc_cnt;
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 0);
        prog_valid = 1'b0;
        expect_v(K_ACC, 32'(acc0 + 16), "full load accepts");
        expect_status("full load");
        tick();

        // Overrun while full sets the sticky error and writes nothing
        send(8'hFF, 0);
        prog_valid = 1'b0;
        expect_status("overrun");
        leave_load();
        expect_status("idle after done");

        // Run-mode reads, including the enable gate
        check_read(3, "run");
        for (int i = 0; i < 6; i++) check_read(int'($urandom_range(0, 15)), "run rand");
        check_read(15, "run last");
        CE_bar = 1'b1;
        addr   = 4'd3;
        expect_v(K_EN,  32'd0, "CE_bar high ram_out_en");
        expect_v(K_OUT, 32'd0, "CE_bar high ram_output");
        tick();

        // Partial load with CE_bar asserted during program mode, aborted on the last handshake
        CE_bar = 1'b0;
        enter_load();
        expect_status("reload entry");
        expect_v(K_EN,  32'd0, "prog mode ram_out_en");
        expect_v(K_OUT, 32'd0, "prog mode ram_output");
        for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), int'($urandom_range(0, 2)));
        prog_valid = 1'b1;
        prog_data  = 8'hA4;
        prog_mode  = 1'b0;
        tick();
        m_mem[4]     = 8'hA4;
        m_loaded     = 5;
        m_in_session = 1'b0;
        prog_valid   = 1'b0;
        expect_status("abort");
        tick();
        for (int i = 0; i < 16; i++) check_read(i, "after abort");

        // Clear in the middle of a load: the pending byte is dropped
        CE_bar = 1'b1;
        enter_load();
        for (int i = 0; i < 7; i++) send(8'($urandom), int'($urandom_range(0, 1)));
        prog_valid = 1'b1;
        prog_data  = 8'h55;
        #2;
        CLR = 1'b1;
        tick();
        m_in_session = 1'b0;
        m_full       = 1'b0;
        m_loaded     = 0;
        m_done       = 1'b0;
        m_err        = 1'b0;
        expect_status("clear mid-load");
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        tick();
        CLR = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) check_read(i, "after clear");

        // Randomised full session with idle gaps
        CE_bar = 1'b1;
        enter_load();
        acc0 = acc_cnt;
        for (int i = 0; i < 16; i++) send(8'($urandom), int'($urandom_range(0, 2)));
        prog_valid = 1'b0;
        expect_v(K_ACC, 32'(acc0 + 16), "random load accepts");
        expect_status("random load");
        tick();
        leave_load();
        for (int i = 0; i < 16; i++) check_read(i, "random readback");

        // Let the monitor drain, bounded
        for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge CLK);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
